// File: rtl/em4100_sequencer.sv
// EM4100 tag-ID sequencer: rotates through a table of 40-bit IDs, feeding one
// slot at a time to the encoder. Optional inter-slot gap: EM4100_SEQ_GAP_EN.
module em4100_sequencer #(
  parameter int SLOTS        = 4,
  parameter int FRAME_CYCLES = 74,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(SLOTS)-1:0]   wr_slot,
  input  logic [39:0]                wr_id,
  input  logic                       wr_valid,
  input  logic [3:0]                 repeat_cnt,
  input  logic                       start,
  input  logic                       stop,
  output logic                       enc_tx,
  output logic [39:0]                enc_data,
  output logic                       busy,
  output logic [$clog2(SLOTS)-1:0]   cur_slot,
  output logic                       frame_done
);

  localparam int SW     = $clog2(SLOTS);
  localparam int CMAX   = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0]    ST_IDLE    = 2'd0;
  localparam logic [1:0]    ST_LOAD    = 2'd1;
  localparam logic [1:0]    ST_SEND    = 2'd2;
`ifdef EM4100_SEQ_GAP_EN
  localparam logic [1:0]    ST_GAP     = 2'd3;
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
`endif
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [SW-1:0] SLOT_ONE   = SW'(1);

  logic [SLOTS-1:0][39:0] id_r;
  logic [SLOTS-1:0]       valid_r;

  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]    rep_r, rep_nxt_s;
  logic [SW-1:0] slot_r, slot_nxt_s;
  logic [39:0]   data_r, data_nxt_s;
  logic          stop_pend_r, stop_pend_nxt_s;
  logic          enc_tx_r, busy_r, frame_done_r;
  logic [SW:0]   sel_s, adv_s;

  // First valid slot at or after 'from', wrapping; MSB of result is the found flag.
  function automatic logic [SW:0] find_next(input logic [SLOTS-1:0] v,
                                            input logic [SW-1:0]    from);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    res = {1'b0, {SW{1'b0}}};
    for (int i = SLOTS - 1; i >= 0; i--) begin
      idx = from + i[SW-1:0];
      if (v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // ID table; only wr_en writes it, reset invalidates every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r    <= '0;
      valid_r <= '0;
    end else if (wr_en) begin
      id_r[wr_slot]    <= wr_id;
      valid_r[wr_slot] <= wr_valid;
    end
  end

  // Next-state logic; enc_data and cur_slot are chosen on the way into LOAD
  // so the encoder sees a stable ID for the whole LOAD cycle.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    rep_nxt_s       = rep_r;
    slot_nxt_s      = slot_r;
    data_nxt_s      = data_r;
    stop_pend_nxt_s = stop_pend_r | stop;
    sel_s           = find_next(valid_r, slot_r);
    adv_s           = find_next(valid_r, slot_r + SLOT_ONE);

    case (state_r)
      ST_IDLE: begin
        stop_pend_nxt_s = 1'b0;
        if (start && !stop && sel_s[SW]) begin
          state_nxt_s = ST_LOAD;
          slot_nxt_s  = sel_s[SW-1:0];
          data_nxt_s  = id_r[sel_s[SW-1:0]];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        state_nxt_s = ST_SEND;
        cnt_nxt_s   = {CW{1'b0}};
        rep_nxt_s   = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
      end

      ST_SEND: begin
        if (cnt_r == FRAME_LAST) begin
          cnt_nxt_s = {CW{1'b0}};
          if (stop_pend_r || stop) begin
            state_nxt_s     = ST_IDLE;
            stop_pend_nxt_s = 1'b0;
          end else if (rep_r > 4'd1) begin
            rep_nxt_s = rep_r - 4'd1;
          end else begin
            rep_nxt_s = 4'd0;
            if (!adv_s[SW]) begin
              state_nxt_s = ST_IDLE;
            end else begin
              slot_nxt_s = adv_s[SW-1:0];
`ifdef EM4100_SEQ_GAP_EN
              state_nxt_s = ST_GAP;
`else
              data_nxt_s  = id_r[adv_s[SW-1:0]];
              state_nxt_s = ST_LOAD;
`endif
            end
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end

`ifdef EM4100_SEQ_GAP_EN
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_nxt_s = {CW{1'b0}};
          if (stop_pend_r || stop) begin
            state_nxt_s     = ST_IDLE;
            stop_pend_nxt_s = 1'b0;
          end else if (sel_s[SW]) begin
            state_nxt_s = ST_LOAD;
            slot_nxt_s  = sel_s[SW-1:0];
            data_nxt_s  = id_r[sel_s[SW-1:0]];
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`endif

      default: begin
        state_nxt_s     = ST_IDLE;
        stop_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered encoder-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      rep_r        <= 4'd0;
      slot_r       <= {SW{1'b0}};
      data_r       <= 40'd0;
      stop_pend_r  <= 1'b0;
      enc_tx_r     <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      rep_r        <= rep_nxt_s;
      slot_r       <= slot_nxt_s;
      data_r       <= data_nxt_s;
      stop_pend_r  <= stop_pend_nxt_s;
      enc_tx_r     <= (state_nxt_s == ST_SEND);
      busy_r       <= (state_nxt_s != ST_IDLE);
      frame_done_r <= (state_nxt_s == ST_SEND) && (cnt_nxt_s == FRAME_LAST);
    end
  end

  assign enc_tx     = enc_tx_r;
  assign enc_data   = data_r;
  assign busy       = busy_r;
  assign cur_slot   = slot_r;
  assign frame_done = frame_done_r;

endmodule
